// File: rtl/dma_dsc_cache_reader_pkg.sv
// Shared sizes and types for the DMA descriptor cache read controller.
package dma_dsc_pkg;
    localparam int DSC_DW     = 64;
    localparam int DSC_DEPTH  = 4;
    localparam int DSC_AW     = $clog2(DSC_DEPTH);
    localparam int DSC_STAGES = 2;   // issue -> SRAM data reg -> skid capture
    localparam int DSC_SKID   = 2;   // output skid entries; also the read credit limit

    typedef logic [DSC_AW-1:0] dsc_ptr_t;
    typedef logic [DSC_DW-1:0] dsc_word_t;
endpackage

// File: rtl/dma_dsc_cache_reader_if.sv
// Writer, SRAM and descriptor-stream signals of the descriptor cache reader.
interface dma_dsc_cache_reader_if #(
    parameter int AW = dma_dsc_pkg::DSC_AW,
    parameter int DW = dma_dsc_pkg::DSC_DW
) ();
    logic          wr_push;
    logic          wr_full;
    logic          w_en;
    logic [AW-1:0] w_addr;
    logic [AW-1:0] r_addr;
    logic          r_addr_en;
    logic          r_data_en;
    logic [DW-1:0] r_data;
    logic [DW-1:0] dsc_data;
    logic          dsc_valid;
    logic          dsc_ready;
    logic [AW:0]   count;

    modport master (
        input  wr_push, r_data, dsc_ready,
        output wr_full, w_en, w_addr, r_addr, r_addr_en, r_data_en,
               dsc_data, dsc_valid, count
    );

    modport slave (
        output wr_push, r_data, dsc_ready,
        input  wr_full, w_en, w_addr, r_addr, r_addr_en, r_data_en,
               dsc_data, dsc_valid, count
    );
endinterface

// File: rtl/dma_dsc_cache_reader_skid2.sv
// Two-entry valid/ready FIFO that re-times SRAM read data into the descriptor stream.
module dma_dsc_skid2
    import dma_dsc_pkg::*;
#(
    parameter int DW = DSC_DW
) (
    input  logic          clk_i,
    input  logic          clr_i,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic [1:0]    count_o
);
    logic [1:0][DW-1:0] mem_q, mem_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic [1:0]         cnt_q, cnt_d;

    // The upstream credit check guarantees a push never lands on a full FIFO.
    always_comb begin
        mem_d = mem_q;
        if (push_i) begin
            mem_d[wr_q] = data_i;
        end
        wr_d  = wr_q ^ push_i;
        rd_d  = rd_q ^ pop_i;
        cnt_d = cnt_q + 2'(push_i) - 2'(pop_i);
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            mem_q <= '0;
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    assign valid_o = (cnt_q != '0);
    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;
endmodule

// File: rtl/dma_dsc_cache_reader.sv
// Read-side controller for the descriptor cache SRAM: pointers, occupancy,
// write gating, 2-cycle read issue and re-timing into a valid/ready stream.
module dma_dsc_cache_reader
    import dma_dsc_pkg::*;
#(
    parameter int DEPTH = DSC_DEPTH,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = DSC_DW
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic flush_i,
    dma_dsc_cache_reader_if.master bus
);
    localparam int STAGES = DSC_STAGES;
    localparam int CW     = AW + 1;

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     avail_q, avail_d;
    logic              wr_full_q, wr_full_d;
    logic [STAGES:1]   vld_pipe_q, vld_pipe_d;

    logic              clr;
    logic              w_en;
    logic              issue;
    logic              pop;
    logic [2:0]        credit_used;
    logic [2:0]        credit_lim;
    logic              skid_valid;
    logic [1:0]        skid_cnt;
    logic [DW-1:0]     skid_data;

    assign clr = rst_i | flush_i;

    // Every issued read owns a skid slot from issue until it is popped, so
    // reads in the pipe plus words in the skid never exceed the skid depth.
    always_comb begin
        pop         = skid_valid & bus.dsc_ready;
        w_en        = bus.wr_push & ~wr_full_q & ~clr;
        credit_used = 3'($countones(vld_pipe_q)) + 3'(skid_cnt);
        credit_lim  = 3'(DSC_SKID) + 3'(pop);
        issue       = (avail_q != '0) & (credit_used < credit_lim) & ~clr;

        wr_ptr_d    = wr_ptr_q + AW'(w_en);
        rd_ptr_d    = rd_ptr_q + AW'(issue);
        count_d     = count_q + CW'(w_en) - CW'(pop);
        avail_d     = avail_q + CW'(w_en) - CW'(issue);
        wr_full_d   = (count_d == CW'(DEPTH));
        vld_pipe_d  = {vld_pipe_q[STAGES-1:1], issue};
    end

    // avail is registered, so a word written at an edge is only addressed a
    // cycle later: the SRAM never sees read-during-write on one slot.
    always_ff @(posedge clk_i) begin
        if (clr) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            avail_q    <= '0;
            wr_full_q  <= 1'b0;
            vld_pipe_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            avail_q    <= avail_d;
            wr_full_q  <= wr_full_d;
            vld_pipe_q <= vld_pipe_d;
        end
    end

    dma_dsc_skid2 #(
        .DW (DW)
    ) u_skid (
        .clk_i   (clk_i),
        .clr_i   (clr),
        .push_i  (vld_pipe_q[STAGES]),
        .data_i  (bus.r_data),
        .pop_i   (pop),
        .valid_o (skid_valid),
        .data_o  (skid_data),
        .count_o (skid_cnt)
    );

    assign bus.wr_full   = wr_full_q;
    assign bus.w_en      = w_en;
    assign bus.w_addr    = wr_ptr_q;
    assign bus.r_addr    = rd_ptr_q;
    assign bus.r_addr_en = issue;
    assign bus.r_data_en = vld_pipe_q[1];
    assign bus.dsc_data  = skid_data;
    assign bus.dsc_valid = skid_valid;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_dma_dsc_cache_reader.sv
// Bench for dma_dsc_cache_reader: SRAM model, timeline reference model, directed and random traffic.
module tb_dma_dsc_cache_reader;
    import dma_dsc_pkg::*;

    localparam int DEPTH = DSC_DEPTH;

    logic      clk = 1'b0;
    logic      rst;
    logic      flush;
    dsc_word_t wr_word;

    dma_dsc_cache_reader_if bus ();

    dma_dsc_cache_reader dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // SRAM: registered address stage, registered data stage
    dsc_word_t         mem [DEPTH];
    logic [DSC_AW-1:0] sram_a_q = '0;
    dsc_word_t         sram_d_q = '0;
    initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (bus.w_en)      mem[bus.w_addr] <= wr_word;
        if (bus.r_addr_en) sram_a_q <= bus.r_addr;
        if (bus.r_data_en) sram_d_q <= mem[sram_a_q];
    end
    assign bus.r_data = sram_d_q;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: accepted words in order, issue times of reads still in the
    // SRAM pipe (captured 2 cycles after the issue cycle), and words sitting in the skid.
    dsc_word_t mq[$];
    int        iss_t[$];
    int        skid_n = 0, wr_tot = 0, rd_tot = 0, cyc = 0;
    bit        rde_exp = 1'b0;
    bit        m_full, m_wen, m_pop, m_iss;
    int        n_iss_dut = 0, dut_out = 0, dut_out_max = 0;
    dsc_word_t plog[$];

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            mq.delete(); iss_t.delete();
            skid_n = 0; wr_tot = 0; rd_tot = 0; rde_exp = 1'b0; dut_out = 0;
        end else begin
            m_full = (mq.size() == DEPTH);
            m_wen  = bus.wr_push && !m_full && !flush;
            m_pop  = (skid_n > 0) && bus.dsc_ready;
            m_iss  = (wr_tot > rd_tot) && ((iss_t.size() + skid_n - (m_pop ? 1 : 0)) < DSC_SKID) && !flush;

            chk("wr_full",   64'(bus.wr_full),   64'(m_full));
            chk("w_en",      64'(bus.w_en),      64'(m_wen));
            chk("w_addr",    64'(bus.w_addr),    64'(wr_tot % DEPTH));
            chk("r_addr",    64'(bus.r_addr),    64'(rd_tot % DEPTH));
            chk("r_addr_en", 64'(bus.r_addr_en), 64'(m_iss));
            chk("r_data_en", 64'(bus.r_data_en), 64'(rde_exp));
            chk("count",     64'(bus.count),     64'(mq.size()));
            chk("dsc_valid", 64'(bus.dsc_valid), 64'(skid_n > 0));
            if (skid_n > 0) chk("dsc_data", bus.dsc_data, mq[0]);

            if (bus.r_addr_en) begin n_iss_dut++; dut_out++; end
            if (bus.dsc_valid && bus.dsc_ready) begin plog.push_back(bus.dsc_data); dut_out--; end
            if (dut_out > dut_out_max) dut_out_max = dut_out;

            if (flush) begin
                mq.delete(); iss_t.delete();
                skid_n = 0; wr_tot = 0; rd_tot = 0; rde_exp = 1'b0; dut_out = 0;
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_wen) begin mq.push_back(wr_word); wr_tot++; end
                while (iss_t.size() > 0 && iss_t[0] + 2 == cyc) begin
                    void'(iss_t.pop_front());
                    skid_n++;
                end
                if (m_pop) skid_n--;
                if (m_iss) begin iss_t.push_back(cyc); rd_tot++; end
                rde_exp = m_iss;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int        base, first, cnt4, cnt5, idx, t;
    dsc_word_t fdata;
    bit        acc_last;

    initial begin
        rst = 1'b1; flush = 1'b0; wr_word = '0;
        bus.wr_push = 1'b0; bus.dsc_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_wr_full",   64'(bus.wr_full),   0);
        chk("rst_count",     64'(bus.count),     0);
        chk("rst_dsc_valid", 64'(bus.dsc_valid), 0);
        chk("rst_dsc_data",  bus.dsc_data,       0);
        chk("rst_r_addr_en", 64'(bus.r_addr_en), 0);
        chk("rst_r_data_en", 64'(bus.r_data_en), 0);
        chk("rst_w_addr",    64'(bus.w_addr),    0);
        chk("rst_r_addr",    64'(bus.r_addr),    0);

        // fill with the consumer stalled
        base = n_iss_dut;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            bus.wr_push = 1'b1;
            wr_word = 64'hA0 + 64'(i);
            @(posedge clk); #1;
        end
        wr_word = 64'hA4;
        @(negedge clk);
        chk("fill_count",   64'(bus.count),   4);
        chk("fill_wr_full", 64'(bus.wr_full), 1);
        chk("fifth_w_en",   64'(bus.w_en),    0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("issue_stall", 64'(n_iss_dut - base), 2);

        // full with a same-cycle pop: push dropped, retry accepted
        @(posedge clk); #1;
        plog.delete();
        bus.dsc_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_w_en", 64'(bus.w_en), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("full_pop_count", 64'(bus.count), 3);
        chk("retry_w_en",     64'(bus.w_en),  1);
        @(posedge clk); #1;
        bus.wr_push = 1'b0;
        for (int k = 0; k < 40 && bus.count != 0; k++) @(negedge clk);
        chk("drain_count", 64'(bus.count), 0);
        chk("drain_len",   64'(plog.size()), 5);
        if (plog.size() == 5)
            for (int i = 0; i < 5; i++) chk("drain_order", plog[i], 64'hA0 + 64'(i));

        // single word latency
        @(posedge clk); #1;
        bus.wr_push = 1'b1; wr_word = 64'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.wr_push = 1'b0;
        first = 0; cnt4 = -1; cnt5 = -1; fdata = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 4) cnt4 = int'(bus.count);
            if (k == 5) cnt5 = int'(bus.count);
            if (bus.dsc_valid && first == 0) begin first = k; fdata = bus.dsc_data; end
        end
        chk("first_word_lat",  64'(first), 4);
        chk("first_word_data", fdata,      64'hDEAD_BEEF);
        chk("lat_count_held",  64'(cnt4),  1);
        chk("lat_count_zero",  64'(cnt5),  0);

        // stream 0..9 with a 1010 ready pattern
        plog.delete();
        idx = 0; t = 0;
        while (plog.size() < 10 && t < 200) begin
            @(posedge clk); #1;
            bus.dsc_ready = (t % 2 == 0);
            bus.wr_push   = (idx < 10);
            wr_word       = 64'(idx);
            @(negedge clk);
            if (bus.w_en) idx++;
            t++;
        end
        @(posedge clk); #1;
        bus.wr_push = 1'b0; bus.dsc_ready = 1'b0;
        chk("stream_len", 64'(plog.size()), 10);
        if (plog.size() == 10)
            for (int i = 0; i < 10; i++) chk("stream_order", plog[i], 64'(i));

        // flush with two reads in flight
        bus.wr_push = 1'b1; wr_word = 64'h5A5A_0001;
        @(posedge clk); #1;
        wr_word = 64'h5A5A_0002;
        @(posedge clk); #1;
        bus.wr_push = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_inflight", 64'(bus.r_data_en), 1);
        @(posedge clk); #1;
        flush = 1'b0;
        bus.dsc_ready = 1'b1;
        @(negedge clk);
        chk("flush_valid",     64'(bus.dsc_valid), 0);
        chk("flush_count",     64'(bus.count),     0);
        chk("flush_w_addr",    64'(bus.w_addr),    0);
        chk("flush_r_addr",    64'(bus.r_addr),    0);
        chk("flush_r_data_en", 64'(bus.r_data_en), 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("flush_stale_valid", 64'(bus.dsc_valid), 0);
        end

        // random traffic; the writer holds a refused word until it is taken
        acc_last = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            if (!(bus.wr_push && !acc_last)) begin
                bus.wr_push = ($urandom_range(0, 99) < 60);
                wr_word     = {$urandom, $urandom};
            end
            bus.dsc_ready = ($urandom_range(0, 99) < 20 + 35 * (c / 500));
            flush         = ($urandom_range(0, 199) == 0);
            @(negedge clk);
            acc_last = bus.w_en;
        end
        @(posedge clk); #1;
        flush = 1'b0; bus.wr_push = 1'b0; bus.dsc_ready = 1'b1;
        for (int k = 0; k < 40 && bus.count != 0; k++) @(negedge clk);
        @(negedge clk);
        chk("final_count",     64'(bus.count),       0);
        chk("outstanding_max", 64'(dut_out_max > 2), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
